// File: rtl/issue_dispatch.sv
// Issue buffer between decode and the execution units: an in-order circular FIFO
// whose head entry is steered to the ALU RS, branch unit or load-store unit by fu_sel.
package issue_dispatch_pkg;

  typedef enum logic [2:0] {
    FU_SEL_NONE   = 3'd0,
    FU_SEL_RS     = 3'd1,
    FU_SEL_BRANCH = 3'd2,
    FU_SEL_LOAD   = 3'd3
  } fu_sel_e;

  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic [31:0] pc;
    logic [1:0]  thread_id;
    logic [2:0]  fu_sel;
  } decode_issue_struct_o;

endpackage

module issue_dispatch
  import issue_dispatch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  decode_issue_struct_o       issue_i,
  input  logic                       issue_valid_i,
  output logic                       stall_o,
  input  logic                       flush_i,
  output logic                       rs_valid_o,
  output logic                       br_valid_o,
  output logic                       ld_valid_o,
  input  logic                       rs_ready_i,
  input  logic                       br_ready_i,
  input  logic                       ld_ready_i,
  output decode_issue_struct_o       disp_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       illegal_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = DEPTH[PW:0];

  typedef enum logic [1:0] {
    ROUTE_RS,
    ROUTE_BR,
    ROUTE_LD,
    ROUTE_ILL
  } route_e;

  decode_issue_struct_o mem [DEPTH];
  decode_issue_struct_o head;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [PW:0]          count;
  route_e               route;
  logic                 offer;
  logic                 push;
  logic                 pop;

  assign head    = mem[rd_ptr];
  assign disp_o  = head;
  assign count_o = count;
  assign stall_o = (count == FULL_COUNT);

  always_comb begin
    route = ROUTE_ILL;
    case (head.fu_sel)
      FU_SEL_NONE,
      FU_SEL_RS:     route = ROUTE_RS;
      FU_SEL_BRANCH: route = ROUTE_BR;
      FU_SEL_LOAD:   route = ROUTE_LD;
      default:       route = ROUTE_ILL;
    endcase
  end

  // Flush suppresses both the offer and the pop, so nothing leaves during a flush cycle.
  assign offer      = (count != '0) && !flush_i;
  assign rs_valid_o = offer && (route == ROUTE_RS);
  assign br_valid_o = offer && (route == ROUTE_BR);
  assign ld_valid_o = offer && (route == ROUTE_LD);

  assign pop  = (rs_valid_o && rs_ready_i) ||
                (br_valid_o && br_ready_i) ||
                (ld_valid_o && ld_ready_i) ||
                (offer && (route == ROUTE_ILL));
  // Full is judged on the pre-pop count: no push slips in while a full buffer drains.
  assign push = issue_valid_i && !stall_o && !flush_i;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= issue_i;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      illegal_o <= 1'b0;
    end else if (flush_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      illegal_o <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      illegal_o <= offer && (route == ROUTE_ILL);
    end
  end

endmodule

// File: tb/tb_issue_dispatch.sv
// Bench for issue_dispatch: directed vector table, hand sequences for fill/flush/reset,
// then random traffic checked against a queue-based reference model.
module tb_issue_dispatch;
  import issue_dispatch_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  decode_issue_struct_o issue_i;
  logic                 issue_valid_i;
  logic                 stall_o;
  logic                 flush_i;
  logic                 rs_valid_o, br_valid_o, ld_valid_o;
  logic                 rs_ready_i, br_ready_i, ld_ready_i;
  decode_issue_struct_o disp_o;
  logic [2:0]           count_o;
  logic                 illegal_o;

  int checks = 0;
  int errors = 0;

  issue_dispatch #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_i       (issue_i),
    .issue_valid_i (issue_valid_i),
    .stall_o       (stall_o),
    .flush_i       (flush_i),
    .rs_valid_o    (rs_valid_o),
    .br_valid_o    (br_valid_o),
    .ld_valid_o    (ld_valid_o),
    .rs_ready_i    (rs_ready_i),
    .br_ready_i    (br_ready_i),
    .ld_ready_i    (ld_ready_i),
    .disp_o        (disp_o),
    .count_o       (count_o),
    .illegal_o     (illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [2:0]  fu;
    logic [31:0] pc;
    bit          fl, rr, brr, lr;
    bit          e_rs, e_br, e_ld, e_stall;
    logic [31:0] e_pc;
    int          e_cnt;
    bit          e_ill;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [2:0] fu, input logic [31:0] pc,
                       input bit fl, input bit rr, input bit brr, input bit lr);
    issue_valid_i       = v;
    issue_i.imm         = pc ^ 32'hA5A5_0000;
    issue_i.rs1         = pc[4:0];
    issue_i.rs2         = pc[6:2];
    issue_i.rd          = pc[8:4];
    issue_i.alu_op      = pc[3:0];
    issue_i.pc          = pc;
    issue_i.thread_id   = pc[1:0];
    issue_i.fu_sel      = fu;
    flush_i             = fl;
    rs_ready_i          = rr;
    br_ready_i          = brr;
    ld_ready_i          = lr;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step_chk(input string tag, input bit v, input logic [2:0] fu, input logic [31:0] pc,
                          input bit fl, input bit rr, input bit brr, input bit lr,
                          input bit e_rs, input bit e_br, input bit e_ld, input bit e_stall,
                          input logic [31:0] e_pc, input int e_cnt, input bit e_ill);
    drive(v, fu, pc, fl, rr, brr, lr);
    #1;
    chk({tag, ".rs_valid"}, 128'(rs_valid_o), 128'(e_rs));
    chk({tag, ".br_valid"}, 128'(br_valid_o), 128'(e_br));
    chk({tag, ".ld_valid"}, 128'(ld_valid_o), 128'(e_ld));
    chk({tag, ".stall"},    128'(stall_o),    128'(e_stall));
    if (e_rs || e_br || e_ld) chk({tag, ".disp_pc"}, 128'(disp_o.pc), 128'(e_pc));
    @(posedge clk);
    #1;
    chk({tag, ".count"},   128'(count_o),   128'(e_cnt));
    chk({tag, ".illegal"}, 128'(illegal_o), 128'(e_ill));
    @(negedge clk);
  endtask

  decode_issue_struct_o model_q [$];
  bit                   model_ill;

  initial begin
    vecs = '{
      // single ALU op
      '{1, 3'd1, 32'h100, 0, 1, 0, 0,  0, 0, 0, 0, 32'h0,   1, 0},
      '{0, 3'd1, 32'h0,   0, 1, 0, 0,  1, 0, 0, 0, 32'h100, 0, 0},
      // head-of-line: blocked load holds back a ready branch
      '{1, 3'd3, 32'h200, 0, 0, 0, 0,  0, 0, 0, 0, 32'h0,   1, 0},
      '{1, 3'd2, 32'h204, 0, 0, 1, 0,  0, 0, 1, 0, 32'h200, 2, 0},
      '{0, 3'd0, 32'h0,   0, 0, 1, 0,  0, 0, 1, 0, 32'h200, 2, 0},
      '{0, 3'd0, 32'h0,   0, 0, 1, 1,  0, 0, 1, 0, 32'h200, 1, 0},
      '{0, 3'd0, 32'h0,   0, 0, 1, 0,  0, 1, 0, 0, 32'h204, 0, 0},
      // illegal fu_sel: dropped unoffered, one-cycle pulse afterwards
      '{1, 3'd5, 32'h300, 0, 1, 1, 1,  0, 0, 0, 0, 32'h0,   1, 0},
      '{0, 3'd0, 32'h0,   0, 1, 1, 1,  0, 0, 0, 0, 32'h0,   0, 1},
      '{0, 3'd0, 32'h0,   0, 1, 1, 1,  0, 0, 0, 0, 32'h0,   0, 0},
      // FU_SEL_NONE goes to the ALU RS
      '{1, 3'd0, 32'h400, 0, 0, 0, 0,  0, 0, 0, 0, 32'h0,   1, 0},
      '{0, 3'd0, 32'h0,   0, 0, 0, 0,  1, 0, 0, 0, 32'h400, 1, 0},
      '{0, 3'd0, 32'h0,   0, 1, 0, 0,  1, 0, 0, 0, 32'h400, 0, 0}
    };

    rst_n = 1'b0;
    drive(0, 3'd0, 32'h0, 0, 0, 0, 0);
    #12;
    chk("reset.count",    128'(count_o),    128'(0));
    chk("reset.stall",    128'(stall_o),    128'(0));
    chk("reset.illegal",  128'(illegal_o),  128'(0));
    chk("reset.valids",   128'({rs_valid_o, br_valid_o, ld_valid_o}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      step_chk($sformatf("vec%0d", i), vecs[i].v, vecs[i].fu, vecs[i].pc,
               vecs[i].fl, vecs[i].rr, vecs[i].brr, vecs[i].lr,
               vecs[i].e_rs, vecs[i].e_br, vecs[i].e_ld, vecs[i].e_stall,
               vecs[i].e_pc, vecs[i].e_cnt, vecs[i].e_ill);
    end

    // Fill past DEPTH with nothing ready; 5th push stalls until a slot frees.
    for (int k = 0; k < 5; k++) begin
      step_chk($sformatf("fill%0d", k), 1, 3'd1, 32'h500 + 32'(k * 4), 0, 0, 0, 0,
               k > 0, 0, 0, k == 4, 32'h500, (k < 4) ? k + 1 : 4, 0);
    end
    step_chk("fill_pop_full", 1, 3'd1, 32'h510, 0, 1, 0, 0, 1, 0, 0, 1, 32'h500, 3, 0);
    step_chk("fill_push_pop", 1, 3'd1, 32'h510, 0, 1, 0, 0, 1, 0, 0, 0, 32'h504, 3, 0);
    step_chk("drain0", 0, 3'd0, 32'h0, 0, 1, 0, 0, 1, 0, 0, 0, 32'h508, 2, 0);
    step_chk("drain1", 0, 3'd0, 32'h0, 0, 1, 0, 0, 1, 0, 0, 0, 32'h50C, 1, 0);
    step_chk("drain2", 0, 3'd0, 32'h0, 0, 1, 0, 0, 1, 0, 0, 0, 32'h510, 0, 0);

    // Flush with a simultaneous push and ready: nothing popped, nothing stored.
    for (int k = 0; k < 3; k++) begin
      step_chk($sformatf("pre_flush%0d", k), 1, 3'd1, 32'h600 + 32'(k * 4), 0, 0, 0, 0,
               k > 0, 0, 0, 0, 32'h600, k + 1, 0);
    end
    step_chk("flush",       1, 3'd1, 32'h6FC, 1, 1, 1, 1, 0, 0, 0, 0, 32'h0, 0, 0);
    step_chk("post_flush",  0, 3'd0, 32'h0,   0, 1, 1, 1, 0, 0, 0, 0, 32'h0, 0, 0);
    // An illegal head flushed away must not raise illegal_o.
    step_chk("ill_push",    1, 3'd6, 32'h680, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0);
    step_chk("ill_flush",   0, 3'd0, 32'h0,   1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    step_chk("ill_flush2",  0, 3'd0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);

    // Asynchronous reset between edges with two entries held.
    step_chk("ar_push0", 1, 3'd1, 32'h700, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   1, 0);
    step_chk("ar_push1", 1, 3'd3, 32'h704, 0, 0, 0, 0, 1, 0, 0, 0, 32'h700, 2, 0);
    drive(0, 3'd0, 32'h0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.count",  128'(count_o),  128'(0));
    chk("async_rst.valids", 128'({rs_valid_o, br_valid_o, ld_valid_o}), 128'(0));
    chk("async_rst.stall",  128'(stall_o),  128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step_chk("first_push", 1, 3'd2, 32'h720, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   1, 0);
    step_chk("first_pop",  0, 3'd0, 32'h0,   0, 0, 1, 0, 0, 1, 0, 0, 32'h720, 0, 0);

    // Random traffic against the queue model; buffer is empty here.
    model_q.delete();
    model_ill = 0;
    for (int n = 0; n < 1500; n++) begin
      int unsigned pr;
      int unsigned sel;
      int          sz;
      bit          has, e_rs, e_br, e_ld, e_il, pop, push;
      logic [2:0]  f;
      decode_issue_struct_o inw;

      pr  = (n < 750) ? 3 : 1;
      sel = $urandom_range(0, 9);
      inw.imm       = $urandom;
      inw.rs1       = 5'($urandom);
      inw.rs2       = 5'($urandom);
      inw.rd        = 5'($urandom);
      inw.alu_op    = 4'($urandom);
      inw.pc        = $urandom;
      inw.thread_id = 2'($urandom);
      inw.fu_sel    = (sel < 4) ? 3'(sel) : 3'($urandom_range(4, 7));
      issue_i       = inw;
      issue_valid_i = ($urandom_range(0, 9) < 6);
      flush_i       = ($urandom_range(0, 31) == 0);
      rs_ready_i    = ($urandom_range(0, 3) >= pr);
      br_ready_i    = ($urandom_range(0, 3) >= pr);
      ld_ready_i    = ($urandom_range(0, 3) >= pr);
      #1;
      sz   = model_q.size();
      has  = (sz > 0) && !flush_i;
      f    = has ? model_q[0].fu_sel : 3'd0;
      e_rs = has && (f == 3'd0 || f == 3'd1);
      e_br = has && (f == 3'd2);
      e_ld = has && (f == 3'd3);
      e_il = has && (f > 3'd3);
      chk("rnd.rs_valid", 128'(rs_valid_o), 128'(e_rs));
      chk("rnd.br_valid", 128'(br_valid_o), 128'(e_br));
      chk("rnd.ld_valid", 128'(ld_valid_o), 128'(e_ld));
      chk("rnd.stall",    128'(stall_o),    128'(sz == int'(DEPTH)));
      if (e_rs || e_br || e_ld) chk("rnd.disp", 128'(disp_o), 128'(model_q[0]));
      pop  = (e_rs && rs_ready_i) || (e_br && br_ready_i) || (e_ld && ld_ready_i) || e_il;
      push = issue_valid_i && (sz < int'(DEPTH)) && !flush_i;
      if (flush_i) begin
        model_q.delete();
      end else begin
        if (pop)  void'(model_q.pop_front());
        if (push) model_q.push_back(inw);
      end
      model_ill = e_il;
      @(posedge clk);
      #1;
      chk("rnd.count",   128'(count_o),   128'(model_q.size()));
      chk("rnd.illegal", 128'(illegal_o), 128'(model_ill));
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_dispatch.md
ISSUE_DISPATCH -- requirements
Module: issue_dispatch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered issue entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port issue_i  input  decode_issue_struct_o  decoded instruction (imm, rs1, rs2, rd, alu_op, pc, thread_id, fu_sel) from decode.
REQ-005 SHALL have port issue_valid_i  input  1  issue_i holds a valid instruction.
REQ-006 SHALL have port stall_o  input-side output  1  back-pressure to decode stall_i; high = issue_i not accepted this cycle.
REQ-007 SHALL have port flush_i  input  1  discard all buffered entries.
REQ-008 SHALL have ports rs_valid_o/br_valid_o/ld_valid_o  output  1 each  head entry offered to ALU RS / branch unit / load-store unit.
REQ-009 SHALL have ports rs_ready_i/br_ready_i/ld_ready_i  input  1 each  target accepts offered entry.
REQ-010 SHALL have port disp_o  output  decode_issue_struct_o  head entry payload, shared by all three targets.
REQ-011 SHALL have port count_o  output  $clog2(DEPTH)+1  current occupancy.
REQ-012 SHALL have port illegal_o  output  1  one-cycle pulse when a head entry with unrecognised fu_sel is discarded.

Function
REQ-013 SHALL implement an in-order circular FIFO: write pointer, read pointer, occupancy counter; pointers wrap modulo DEPTH.
REQ-014 SHALL assert stall_o combinationally when count_o == DEPTH; push occurs when issue_valid_i && !stall_o && !flush_i.
REQ-015 SHALL, with count at DEPTH, not accept a push even if a pop occurs the same cycle (no full-bypass).
REQ-016 SHALL route head entry by fu_sel: FU_SEL_RS and FU_SEL_NONE -> rs_valid_o; FU_SEL_BRANCH -> br_valid_o; FU_SEL_LOAD -> ld_valid_o; at most one valid_o high per cycle.
REQ-017 SHALL drive valid_o and disp_o combinationally from the head entry; all valid_o low when count_o == 0; no empty bypass, so minimum push-to-offer latency is 1 cycle.
REQ-018 SHALL pop the head on the edge where its selected valid_o and matching ready_i are both high.
REQ-019 SHALL hold disp_o and the asserted valid_o stable while the matching ready_i is low; a blocked head blocks younger entries (strict in-order).
REQ-020 SHALL, for a head with any other fu_sel code, pop it without offering it (no valid_o) and pulse illegal_o high in the following cycle for exactly one cycle.
REQ-021 SHALL on simultaneous push and pop leave count unchanged and advance both pointers.
REQ-022 SHALL on flush_i clear count and both pointers at the next edge, ignoring same-cycle push and pop; valid_o stay low during the flush cycle.
REQ-023 SHALL never let count_o exceed DEPTH nor underflow below 0.

Reset
REQ-024 SHALL on rst_n low immediately clear pointers, count_o=0, illegal_o=0, all valid_o=0, stall_o=0, independent of clk.
REQ-025 SHALL leave entry payload storage unreset; disp_o is don't-care while count_o == 0.
REQ-026 SHALL accept a push on the first rising edge after rst_n deasserts.

Verification
REQ-027 Single ALU op: push fu_sel=RS, pc=0x100, rs_ready_i=1 -> rs_valid_o high next cycle with disp_o.pc=0x100, popped that edge, count_o back to 0.
REQ-028 Fill: DEPTH=4, push 5 back-to-back with all ready_i=0 -> count_o=4, stall_o high from the 5th push cycle, 5th held; raise rs_ready_i -> 5th accepted, order preserved.
REQ-029 Head-of-line: head fu_sel=LOAD with ld_ready_i=0, next fu_sel=BRANCH with br_ready_i=1 -> br_valid_o stays 0 until ld_ready_i=1, then branch offered next cycle.
REQ-030 Illegal: push entry with undefined fu_sel -> no valid_o, illegal_o pulses once, count_o decrements by 1.
REQ-031 Flush mid-operation: 3 entries, flush_i with simultaneous push and rs_ready_i -> count_o=0 next cycle, pushed entry not stored.
REQ-032 Async reset: assert rst_n low between edges with count_o=2 -> count_o=0 and all valid_o low before the next clk edge.
